// File: rtl/gcd_job_driver.sv
// gcd_job_driver: sequences operand pairs into a start/finish GCD unit, with zero-operand bypass and a WAIT timeout.
module gcd_job_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_finish,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             gcd_clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_error
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {INIT, IDLE, SEND_A, SEND_B, WAIT, CLEAR, OUT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT:   state_d = IDLE;
      IDLE:   if (op_valid) begin
                a_d = op_a;
                b_d = op_b;
                if (op_a == '0 || op_b == '0) begin
                  res_d   = op_a | op_b;
                  err_d   = 1'b0;
                  state_d = OUT;
                end else state_d = SEND_A;
              end
      SEND_A: state_d = SEND_B;
      SEND_B: begin
                cnt_d   = '0;
                state_d = WAIT;
              end
      WAIT:   if (gcd_finish) begin
                res_d   = gcd_result;
                err_d   = 1'b0;
                state_d = CLEAR;
              end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                res_d   = '0;
                err_d   = 1'b1;
                state_d = CLEAR;
              end else cnt_d = cnt_q + 1'b1;
      CLEAR:  state_d = OUT;
      OUT:    if (res_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end
  // INIT is the reset state, so its clear pulse is held off until reset_n releases
  assign gcd_clear = reset_n && (state_q == INIT || state_q == CLEAR);
  assign op_ready  = state_q == IDLE;
  assign gcd_start = state_q == SEND_A;
  assign gcd_data  = state_q == SEND_A ? a_q : state_q == SEND_B ? b_q : '0;
  assign res_valid = state_q == OUT;
  assign res_data  = res_q;
  assign res_error = err_q;
endmodule

// File: tb/tb_gcd_job_driver.sv
// tb_gcd_job_driver: directed table of GCD jobs plus hand-written reset sequences.
module tb_gcd_job_driver;
  localparam int W  = 8;
  localparam int TO = 16;
  logic clock = 0, reset_n = 0, op_valid = 0, gcd_finish = 0, res_ready = 0;
  logic [W-1:0] op_a = '0, op_b = '0, gcd_result = '0;
  logic op_ready, gcd_start, gcd_clear, res_valid, res_error;
  logic [W-1:0] gcd_data, res_data;
  int vec = 0, bad = 0;

  gcd_job_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .gcd_start(gcd_start), .gcd_data(gcd_data),
    .gcd_finish(gcd_finish), .gcd_result(gcd_result), .gcd_clear(gcd_clear),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic all_zero(input string n);
    chk({n, "_outs"}, {op_ready, gcd_start, gcd_clear, res_valid, res_error, gcd_data, res_data}, 0);
  endtask

  // fin: WAIT cycle (1-based) during which finish is raised; 0 means never
  typedef struct {int a; int b; int fin; int res; int err; int hold;} vec_t;

  task automatic run(input vec_t v);
    int w;
    @(negedge clock);
    chk("op_ready_idle", op_ready, 1);
    op_a = W'(v.a); op_b = W'(v.b); op_valid = 1;
    @(negedge clock);
    op_valid = 0;
    if (v.a == 0 || v.b == 0) chk("zero_no_start", gcd_start, 0);
    else begin
      chk("start_a", gcd_start, 1);
      chk("data_a", gcd_data, v.a);
      @(negedge clock);
      chk("start_b", gcd_start, 0);
      chk("data_b", gcd_data, v.b);
      gcd_result = 8'hA5;
      w = 0;
      for (int i = 0; i < TO + 4; i++) begin
        @(negedge clock);
        if (gcd_clear) break;
        w++;
        if (w == v.fin) begin gcd_finish = 1; gcd_result = W'(v.res); end
      end
      chk("clear_pulse", gcd_clear, 1);
      gcd_finish = 0; gcd_result = '0;
      chk("wait_cycles", w, (v.fin > 0 && v.fin <= TO) ? v.fin : TO);
      @(negedge clock);
      chk("clear_once", gcd_clear, 0);
    end
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, v.res);
    chk("res_error", res_error, v.err);
    chk("op_ready_busy", op_ready, 0);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clock);
      chk("hold_stable", {op_ready, res_valid, res_error, res_data}, {1'b0, 1'b1, 1'(v.err), W'(v.res)});
    end
    res_ready = 1;
    @(negedge clock);
    res_ready = 0;
    chk("op_ready_after", {op_ready, res_valid}, 2'b10);
  endtask

  vec_t tv[6];
  vec_t tv2[2];

  initial begin
    tv[0] = '{12, 18, 4, 6, 0, 0};
    tv[1] = '{7, 0, 0, 7, 0, 0};
    tv[2] = '{0, 0, 0, 0, 0, 0};
    tv[3] = '{5, 9, 0, 0, 1, 0};
    tv[4] = '{20, 8, TO, 4, 0, 5};
    tv[5] = '{255, 17, 1, 17, 0, 2};
    tv2[0] = '{9, 6, 3, 3, 0, 0};
    tv2[1] = '{35, 14, 2, 7, 0, 1};
    repeat (2) @(negedge clock);
    all_zero("in_reset");
    reset_n = 1;
    #1 chk("init_clear", {gcd_clear, op_ready}, 2'b10);
    @(negedge clock);
    chk("init_to_idle", {gcd_clear, op_ready}, 2'b01);
    foreach (tv[i]) run(tv[i]);
    @(negedge clock);
    op_a = 8'd10; op_b = 8'd4; op_valid = 1;
    @(negedge clock);
    op_valid = 0;
    repeat (4) @(negedge clock);
    chk("mid_wait_quiet", {op_ready, gcd_start, gcd_clear, res_valid}, 0);
    reset_n = 0;
    #1 all_zero("mid_reset");
    @(negedge clock);
    all_zero("mid_reset_hold");
    reset_n = 1;
    #1 chk("reinit_clear", {gcd_clear, op_ready}, 2'b10);
    @(negedge clock);
    chk("reinit_idle", {gcd_clear, op_ready, res_valid}, 3'b010);
    foreach (tv2[i]) run(tv2[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
